// File: rtl/cop_ise_mskp_if.sv
// Coprocessor port bundle: core-side instruction/result handshake plus the
// external entropy req/ack channel.
interface cop_ise_mskp_if #(
  parameter int W = 32
);
  logic         cop_valid;
  logic [31:0]  cop_insn;
  logic [W-1:0] cop_rs1;
  logic [W-1:0] cop_rs2;
  logic         cop_ready;
  logic         cop_wr;
  logic         cop_wait;
  logic [W-1:0] cop_rd;
  logic         ent_req;
  logic         ent_ack;
  logic [W-1:0] ent_data;

  // master is the environment (core + entropy source), slave is the coprocessor
  modport master (
    output cop_valid, cop_insn, cop_rs1, cop_rs2, ent_ack, ent_data,
    input  cop_ready, cop_wr, cop_wait, cop_rd, ent_req
  );

  modport slave (
    input  cop_valid, cop_insn, cop_rs1, cop_rs2, ent_ack, ent_data,
    output cop_ready, cop_wr, cop_wait, cop_rd, ent_req
  );
endinterface

// File: rtl/cop_ise_mskp.sv
// Masked ADD/SUB/MUL-low and RDRAND coprocessor. Each result is built from three
// randomly masked partials whose order and inter-phase delays are randomisable.
//
// state | meaning
// IDLE  | waiting for a matching instruction
// REQ   | entropy requested, waiting for ent_ack
// C0-C2 | accumulate masked partial for phase 0..2
// T0-T2 | random delay after phase 0..2
// DONE  | one-cycle result pulse
module cop_ise_mskp #(
  parameter logic [6:0] CUSOPCODE = 7'b0001011,
  parameter int         W         = 32,
  parameter int         TW        = 8
) (
  input  logic         cop_clk,
  input  logic         cop_rst_n,
  cop_ise_mskp_if.slave bus
);

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_MUL = 3'b001;
  localparam logic [2:0] F_RND = 3'b010;
  localparam logic [2:0] F_SUB = 3'b011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_REQ  = 4'd1,
    S_C0   = 4'd2,
    S_T0   = 4'd3,
    S_C1   = 4'd4,
    S_T1   = 4'd5,
    S_C2   = 4'd6,
    S_T2   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    op1, op1_nx, op2, op2_nx;
  logic [W-1:0]    r, r_nx, resreg, resreg_nx;
  logic [6:0]      funct, funct_nx;
  logic            shuf, shuf_nx;
  logic [TW-1:0]   timcnt, timcnt_nx;

  logic [1:0]      phase, rot, msel;
  logic [2:0]      msum;
  state_t          after, tstate;
  logic [W-1:0]    mask, part, acc;
  logic [7:0]      rbyte, msk8, dly8;
  logic [TW-1:0]   dly;
  logic            unused_insn;

  assign unused_insn = ^{bus.cop_insn[24:13], bus.cop_insn[11:7]};

  always_ff @(posedge cop_clk or negedge cop_rst_n) begin
    if (!cop_rst_n) begin
      state  <= S_IDLE;
      op1    <= '0;
      op2    <= '0;
      r      <= '0;
      resreg <= '0;
      funct  <= '0;
      shuf   <= 1'b0;
      timcnt <= '0;
    end else begin
      state  <= state_nx;
      op1    <= op1_nx;
      op2    <= op2_nx;
      r      <= r_nx;
      resreg <= resreg_nx;
      funct  <= funct_nx;
      shuf   <= shuf_nx;
      timcnt <= timcnt_nx;
    end
  end

  // Phase bookkeeping shared by the Ci and Ti states.
  always_comb begin
    phase  = 2'd0;
    after  = S_IDLE;
    tstate = S_IDLE;
    case (state)
      S_C0, S_T0: begin phase = 2'd0; after = S_C1;   tstate = S_T0; end
      S_C1, S_T1: begin phase = 2'd1; after = S_C2;   tstate = S_T1; end
      S_C2, S_T2: begin phase = 2'd2; after = S_DONE; tstate = S_T2; end
      default:    begin phase = 2'd0; after = S_IDLE; tstate = S_IDLE; end
    endcase
  end

  // Masked partial datapath; the three masks sum back to op2 so order is free.
  always_comb begin
    rot  = (shuf && (r[25:24] != 2'd3)) ? r[25:24] : 2'd0;
    msum = {1'b0, phase} + {1'b0, rot};
    msel = (msum >= 3'd3) ? 2'(msum - 3'd3) : msum[1:0];
    case (msel)
      2'd0:    mask = op2 ^ r;
      2'd1:    mask = op2 & r;
      default: mask = ~op2 & r;
    endcase
    case (funct[2:0])
      F_ADD:   part = op1 + mask;
      F_SUB:   part = op1 - mask;
      F_MUL:   part = op1 * mask;
      default: part = '0;
    endcase
    acc = (msel == 2'd2) ? (resreg - part) : (resreg + part);
    case (phase)
      2'd0:    rbyte = r[7:0];
      2'd1:    rbyte = r[15:8];
      default: rbyte = r[23:16];
    endcase
    msk8 = 8'hFF >> (3'd7 - funct[5:3]);
    dly8 = rbyte & msk8;
    dly  = dly8[TW-1:0];
  end

  always_comb begin
    state_nx  = state;
    op1_nx    = op1;
    op2_nx    = op2;
    r_nx      = r;
    resreg_nx = resreg;
    funct_nx  = funct;
    shuf_nx   = shuf;
    timcnt_nx = timcnt;
    case (state)
      S_IDLE: begin
        if (bus.cop_valid && (bus.cop_insn[6:0] == CUSOPCODE)) begin
          op1_nx    = bus.cop_rs1;
          op2_nx    = bus.cop_rs2;
          funct_nx  = bus.cop_insn[31:25];
          shuf_nx   = bus.cop_insn[12];
          resreg_nx = '0;
          case (bus.cop_insn[27:25])
            F_ADD, F_SUB, F_MUL, F_RND: state_nx = S_REQ;
            default:                    state_nx = S_DONE;
          endcase
        end
      end
      S_REQ: begin
        if (bus.ent_ack) begin
          r_nx = bus.ent_data;
          if (funct[2:0] == F_RND) begin
            resreg_nx = bus.ent_data;
            state_nx  = S_DONE;
          end else begin
            state_nx  = S_C0;
          end
        end
      end
      S_C0, S_C1, S_C2: begin
        resreg_nx = acc;
        // A zero delay skips the Ti state so extra latency equals the loaded value.
        if (funct[6] && (dly != '0)) begin
          timcnt_nx = dly;
          state_nx  = tstate;
        end else begin
          state_nx  = after;
        end
      end
      S_T0, S_T1, S_T2: begin
        timcnt_nx = (timcnt == '0) ? '0 : timcnt - TW'(1);
        if (timcnt <= TW'(1)) state_nx = after;
      end
      S_DONE: state_nx = S_IDLE;
      default: begin
        state_nx  = S_IDLE;
        op1_nx    = '0;
        op2_nx    = '0;
        r_nx      = '0;
        resreg_nx = '0;
        funct_nx  = '0;
        shuf_nx   = 1'b0;
        timcnt_nx = '0;
      end
    endcase
  end

  assign bus.ent_req   = (state == S_REQ);
  assign bus.cop_ready = (state == S_DONE);
  assign bus.cop_wr    = (state == S_DONE);
  assign bus.cop_wait  = (state != S_IDLE);
  assign bus.cop_rd    = (state == S_DONE) ? resreg : '0;

endmodule
